// File: rtl/pic_ctl.sv
// rtl/pic_ctl.sv - 8-input 8259-style master interrupt controller
// Edge-latched requests, fixed priority, in-service nesting, toggle handshake to CPU.
module pic_ctl #(
  parameter logic [15:0] PORT_CMD   = 16'h0020,
  parameter logic [15:0] PORT_DATA  = 16'h0021,
  parameter logic [7:0]  VECT_RESET = 8'h08
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        port_clk,
  input  logic [15:0] port,
  input  logic [7:0]  port_o,
  input  logic        port_w,
  output logic [7:0]  port_i,
  output logic        rd_hit,
  input  logic [7:0]  irq_in,
  output logic        intr,
  output logic [7:0]  irq,
  input  logic        intr_latch
);

  typedef enum logic [1:0] {INIT_READY, INIT_ICW2, INIT_ICW3, INIT_ICW4} init_t;
  typedef enum logic {DLV_IDLE, DLV_WAIT} dlv_t;

  init_t       init_state;
  dlv_t        dlv_state;
  logic [7:0]  imr, irr, isr, irq_prev;
  logic [4:0]  vbase;
  logic        rsel, sngl, ic4;

  logic        cmd_hit, data_hit, cmd_wr, data_wr, rd_any;
  logic        icw1, ocw2, ocw3;
  logic [7:0]  edges, eoi_mask, dlv_onehot;
  logic [2:0]  cand;
  logic        found, blocked, deliver;

  assign cmd_hit  = port_clk && (port == PORT_CMD);
  assign data_hit = port_clk && (port == PORT_DATA);
  assign cmd_wr   = cmd_hit && port_w;
  assign data_wr  = data_hit && port_w;
  assign rd_any   = (cmd_hit || data_hit) && !port_w;
  assign icw1     = cmd_wr && port_o[4];
  assign ocw2     = cmd_wr && !port_o[4] && !port_o[3];
  assign ocw3     = cmd_wr && !port_o[4] && port_o[3];
  assign edges    = irq_in & ~irq_prev;

  // Scan upward: any in-service bit seen at or below the candidate blocks it.
  always_comb begin
    cand    = 3'd0;
    found   = 1'b0;
    blocked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found) begin
        if (isr[i]) blocked = 1'b1;
        if (irr[i] && !imr[i]) begin
          cand  = 3'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign deliver = (dlv_state == DLV_IDLE) && found && !blocked &&
                   (intr == intr_latch) && (init_state == INIT_READY) && !cmd_wr;
  assign dlv_onehot = deliver ? (8'd1 << cand) : 8'd0;

  always_comb begin
    eoi_mask = 8'd0;
    if (ocw2 && port_o[5]) begin
      if (port_o[6]) eoi_mask[port_o[2:0]] = 1'b1;
      else           eoi_mask = isr & (~isr + 8'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      imr        <= 8'd0;
      irr        <= 8'd0;
      isr        <= 8'd0;
      irq_prev   <= irq_in;
      vbase      <= VECT_RESET[7:3];
      rsel       <= 1'b0;
      sngl       <= 1'b0;
      ic4        <= 1'b0;
      init_state <= INIT_READY;
      dlv_state  <= DLV_IDLE;
      intr       <= 1'b0;
      irq        <= 8'd0;
      port_i     <= 8'd0;
      rd_hit     <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      rd_hit   <= rd_any;
      if (rd_any) port_i <= cmd_hit ? (rsel ? isr : irr) : imr;

      if (icw1) begin
        imr        <= 8'd0;
        irr        <= 8'd0;
        isr        <= 8'd0;
        rsel       <= 1'b0;
        sngl       <= port_o[1];
        ic4        <= port_o[0];
        init_state <= INIT_ICW2;
        dlv_state  <= DLV_IDLE;
      end else begin
        irr <= (irr & ~dlv_onehot) | edges;
        isr <= (isr & ~eoi_mask) | dlv_onehot;
        if (ocw3 && port_o[1]) rsel <= port_o[0];

        if (data_wr) begin
          case (init_state)
            INIT_ICW2: begin
              vbase      <= port_o[7:3];
              init_state <= !sngl ? INIT_ICW3 : (ic4 ? INIT_ICW4 : INIT_READY);
            end
            INIT_ICW3: init_state <= ic4 ? INIT_ICW4 : INIT_READY;
            INIT_ICW4: init_state <= INIT_READY;
            default:   imr <= port_o;
          endcase
        end

        case (dlv_state)
          DLV_IDLE: begin
            if (deliver) begin
              irq       <= {vbase, cand};
              intr      <= ~intr;
              dlv_state <= DLV_WAIT;
            end
          end
          default: begin
            if (intr_latch == intr) dlv_state <= DLV_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_ctl.sv
// tb/tb_pic_ctl.sv - scoreboard bench for pic_ctl
// Stimulus updates a priority/mask model and queues expected vectors and reads; a monitor checks them.
module tb_pic_ctl;
  localparam logic [15:0] CMD  = 16'h0020;
  localparam logic [15:0] DATA = 16'h0021;

  logic        clock = 1'b0, resetn = 1'b0, port_clk = 1'b0, port_w = 1'b0, intr_latch = 1'b0;
  logic [15:0] port = 16'h0;
  logic [7:0]  port_o = 8'h0, irq_in = 8'h0;
  logic [7:0]  port_i, irq;
  logic        rd_hit, intr;

  always #5 clock = ~clock;

  pic_ctl dut (
    .clock(clock), .resetn(resetn), .port_clk(port_clk), .port(port), .port_o(port_o),
    .port_w(port_w), .port_i(port_i), .rd_hit(rd_hit), .irq_in(irq_in), .intr(intr),
    .irq(irq), .intr_latch(intr_latch)
  );

  int         checks = 0, failures = 0;
  logic [7:0] expq[$];
  logic [7:0] rdq[$];
  logic [7:0] m_irr = 8'h0, m_isr = 8'h0, m_imr = 8'h0;
  logic [4:0] m_vbase = 5'h01;
  bit         ack_en = 1'b1;
  logic       prev_intr = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  // Next vector: lowest unmasked pending request, only if it outranks everything in service.
  function automatic int predict();
    int c = lowest(m_irr & ~m_imr);
    if (c < 8 && c < lowest(m_isr)) return c;
    return -1;
  endfunction

  // Monitor: every intr toggle and every rd_hit pops the matching expectation.
  initial forever begin
    @(negedge clock);
    if (!resetn) prev_intr = intr;
    else begin
      if (intr !== prev_intr) begin
        prev_intr = intr;
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_delivery actual=%h expected=none", irq);
        end else check("vector", irq, expq.pop_front());
      end
      if (rd_hit) begin
        if (rdq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rd_hit actual=%h expected=none", port_i);
        end else check("port_read", port_i, rdq.pop_front());
      end
    end
  end

  // CPU side: acknowledge a pending request after a random delay.
  initial forever begin
    @(negedge clock);
    if (ack_en && resetn && intr !== intr_latch) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      if (ack_en) intr_latch = intr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    port = a; port_o = d; port_w = 1'b1; port_clk = 1'b1;
    @(negedge clock);
    port_clk = 1'b0; port_w = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp);
    @(negedge clock);
    rdq.push_back(exp);
    port = a; port_w = 1'b0; port_clk = 1'b1;
    @(negedge clock);
    port_clk = 1'b0;
  endtask

  task automatic rd_irr(); wr(CMD, 8'h0A); rd(CMD, m_irr); endtask
  task automatic rd_isr(); wr(CMD, 8'h0B); rd(CMD, m_isr); endtask

  task automatic pulse(input logic [7:0] e);
    @(negedge clock); irq_in = e;
    @(negedge clock); irq_in = 8'h00;
    m_irr = m_irr | e;
  endtask

  task automatic wait_q();
    int n = 0;
    while (expq.size() != 0 && n < 40) begin @(negedge clock); n++; end
    check("delivery_seen", 8'(expq.size()), 8'd0);
    expq.delete();
  endtask

  task automatic wait_dlv();
    int n = 0;
    while ((expq.size() != 0 || intr_latch !== intr) && n < 60) begin @(negedge clock); n++; end
    check("delivery_done", 8'(expq.size()), 8'd0);
    expq.delete();
  endtask

  task automatic eoi();
    int k;
    if ($urandom_range(0, 1) == 1) begin
      do k = $urandom_range(0, 7); while (!m_isr[k]);
      m_isr[k] = 1'b0;
      wr(CMD, 8'h60 | 8'(k));
    end else begin
      k = lowest(m_isr);
      if (k < 8) m_isr[k] = 1'b0;
      wr(CMD, 8'h20);
    end
  endtask

  task automatic drain();
    int n;
    for (int g = 0; g < 40; g++) begin
      n = predict();
      if (n >= 0) begin
        expq.push_back({m_vbase, 3'(n)});
        m_irr[n] = 1'b0;
        m_isr[n] = 1'b1;
        wait_dlv();
        if ($urandom_range(0, 1) == 1) eoi();
      end else if (m_isr != 8'h0) eoi();
      else return;
    end
    checks++; failures++;
    $display("FAIL drain_settle actual=%h expected=00", m_isr);
  endtask

  task automatic init_pic(input bit sngl, input bit ic4, input logic [7:0] vb);
    wr(CMD, 8'h10 | {6'b0, sngl, ic4});
    wr(DATA, vb);
    if (!sngl) wr(DATA, 8'($urandom));
    if (ic4)   wr(DATA, 8'($urandom));
    m_irr = 8'h0; m_isr = 8'h0; m_imr = 8'h0; m_vbase = vb[7:3];
  endtask

  initial begin
    irq_in = 8'hFF;
    repeat (3) @(negedge clock);
    check("reset_intr", {7'b0, intr}, 8'h00);
    check("reset_irq", irq, 8'h00);
    check("reset_port_i", port_i, 8'h00);
    check("reset_rd_hit", {7'b0, rd_hit}, 8'h00);
    resetn = 1'b1;
    repeat (6) @(negedge clock);
    irq_in = 8'h00;
    rd(CMD, 8'h00);
    rd(DATA, 8'h00);

    ack_en = 1'b0;
    expq.push_back(8'h08);
    @(negedge clock); irq_in = 8'h01;
    @(negedge clock); irq_in = 8'h00;
    check("intr_after_1_cycle", {7'b0, intr}, 8'h00);
    @(negedge clock);
    check("intr_after_2_cycles", {7'b0, intr}, 8'h01);
    repeat (4) @(negedge clock);
    check("intr_held_no_ack", {7'b0, intr}, 8'h01);
    m_isr = 8'h01;
    rd_isr();
    ack_en = 1'b1;
    wait_dlv();
    wr(CMD, 8'h20);
    m_isr = 8'h00;
    rd_isr();
    wr(CMD, 8'h20);
    rd_isr();

    pulse(8'h03);
    drain();
    m_imr = 8'h01; wr(DATA, m_imr);
    pulse(8'h01);
    repeat (4) @(negedge clock);
    rd_irr();
    m_imr = 8'h00; wr(DATA, m_imr);
    drain();

    ack_en = 1'b0;
    expq.push_back(8'h0A);
    pulse(8'h04);
    wait_q();
    irq_in = 8'hFF; resetn = 1'b0; intr_latch = 1'b0;
    repeat (2) @(negedge clock);
    check("midwait_reset_intr", {7'b0, intr}, 8'h00);
    check("midwait_reset_irq", irq, 8'h00);
    resetn = 1'b1;
    m_irr = 8'h0; m_isr = 8'h0; m_imr = 8'h0; m_vbase = 5'h01;
    ack_en = 1'b1;
    repeat (5) @(negedge clock);
    rd_irr();
    rd_isr();
    irq_in = 8'h00;

    init_pic(1'b1, 1'b1, 8'h70);
    rd(DATA, 8'h00);
    pulse(8'h08);
    drain();

    for (int r = 0; r < 40; r++) begin
      if (r % 10 == 9) init_pic(1'($urandom), 1'($urandom), 8'($urandom));
      m_imr = 8'($urandom) & 8'($urandom);
      wr(DATA, m_imr);
      drain();
      pulse(8'($urandom));
      drain();
      rd_irr();
      rd_isr();
      rd(DATA, m_imr);
    end

    repeat (5) @(negedge clock);
    check("vector_queue_empty", 8'(expq.size()), 8'd0);
    check("read_queue_empty", 8'(rdq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
